// File: rtl/iir_sample_feeder_if.sv
// Sample stream handshake between an upstream producer and the IIR feeder.
// Carries s_data_i/s_valid_i toward the feeder and s_ready_o back upstream.
interface iir_sample_feeder_if #(
    parameter int IN_BITS = 16
) ();
    logic [IN_BITS-1:0] s_data_i;
    logic               s_valid_i;
    logic               s_ready_o;

    modport master (
        output s_data_i,
        output s_valid_i,
        input  s_ready_o
    );

    modport slave (
        input  s_data_i,
        input  s_valid_i,
        output s_ready_o
    );
endinterface

// File: rtl/iir_sample_feeder.sv
// Buffers integer samples in a FIFO and releases one per sample-rate tick
// to an IIR x_i port as Q16.16, holding the word between ticks.
// Ports: clk/rst (sync, active-high), s_if (sample stream, slave side),
// en_i/div_i (tick period = div_i+1 cycles), clr_uf_i (clear underflow),
// x_o/tick_o (output word and its update pulse), underflow_o (sticky),
// level_o (FIFO occupancy).
module iir_sample_feeder #(
    parameter int N_BITS   = 32,
    parameter int IN_BITS  = 16,
    parameter int DEPTH    = 16,
    parameter int DIV_BITS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    iir_sample_feeder_if.slave         s_if,
    input  logic                       en_i,
    input  logic [DIV_BITS-1:0]        div_i,
    input  logic                       clr_uf_i,
    output logic [N_BITS-1:0]          x_o,
    output logic                       tick_o,
    output logic                       underflow_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [IN_BITS-1:0]  r_mem [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [LW-1:0]       r_level;
    logic [DIV_BITS-1:0] r_cnt;
    logic [N_BITS-1:0]   r_x;
    logic                r_tick;
    logic                r_uf;

    logic                w_ready;
    logic                w_push;
    logic                w_pop;
    logic                w_tick;
    logic                w_empty;
    logic [IN_BITS-1:0]  w_head;
    logic [N_BITS-1:0]   w_qx;

    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign w_ready = !rst && (r_level < LW'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_tick  = en_i && (r_cnt >= div_i);
    assign w_push  = s_if.s_valid_i && w_ready;
    // Empty is judged on registered state, so a same-edge push is not seen.
    assign w_pop   = w_tick && !w_empty;
    assign w_head  = r_mem[r_rptr];
    assign w_qx    = N_BITS'($signed({w_head, 16'h0000}));

    assign s_if.s_ready_o = w_ready;
    assign x_o            = r_x;
    assign tick_o         = r_tick;
    assign underflow_o    = r_uf;
    assign level_o        = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= s_if.s_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_cnt   <= '0;
            r_x     <= '0;
            r_tick  <= 1'b0;
            r_uf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            if (!en_i || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_tick <= w_tick;
            if (w_tick) begin
                r_x <= w_empty ? '0 : w_qx;
            end

            // A new underflow wins over a clear on the same edge.
            if (w_tick && w_empty) begin
                r_uf <= 1'b1;
            end else if (clr_uf_i) begin
                r_uf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_iir_sample_feeder.sv
// Directed self-checking bench for iir_sample_feeder.
// Steps the DUT one edge at a time and checks outputs #1 after the edge.
module tb_iir_sample_feeder;
    logic        clk;
    logic        rst;
    logic        en_i;
    logic [15:0] div_i;
    logic        clr_uf_i;
    logic [31:0] x_o;
    logic        tick_o;
    logic        underflow_o;
    logic [4:0]  level_o;

    int checks = 0;
    int errors = 0;
    int acc;
    int n;
    logic w;

    iir_sample_feeder_if #(.IN_BITS(16)) s_if ();

    iir_sample_feeder #(
        .N_BITS(32), .IN_BITS(16), .DEPTH(16), .DIV_BITS(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_if(s_if.slave),
        .en_i(en_i),
        .div_i(div_i),
        .clr_uf_i(clr_uf_i),
        .x_o(x_o),
        .tick_o(tick_o),
        .underflow_o(underflow_o),
        .level_o(level_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until tick_o is seen; returns edges taken, or 0 on timeout.
    task automatic wait_tick(input int max, output int cnt);
        cnt = 0;
        for (int k = 1; k <= max; k++) begin
            step();
            if (tick_o) begin
                cnt = k;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en_i = 1'b0;
        div_i = 16'd3;
        clr_uf_i = 1'b0;
        s_if.s_valid_i = 1'b0;
        s_if.s_data_i = '0;
        step();
        step();
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_x", x_o, 32'd0);
        chk("rst_tick", 32'(tick_o), 32'd0);
        chk("rst_uf", 32'(underflow_o), 32'd0);
        chk("rst_ready", 32'(s_if.s_ready_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(s_if.s_ready_o), 32'd1);

        // Three samples, then tick every 4 cycles.
        s_if.s_valid_i = 1'b1;
        s_if.s_data_i = 16'h0001;
        step();
        s_if.s_data_i = 16'hFFEB;
        step();
        s_if.s_data_i = 16'h7FFF;
        step();
        s_if.s_valid_i = 1'b0;
        chk("lvl3", 32'(level_o), 32'd3);
        en_i = 1'b1;
        wait_tick(10, n);
        chk("t1_period", 32'(n), 32'd4);
        chk("t1_x", x_o, 32'h00010000);
        wait_tick(10, n);
        chk("t2_period", 32'(n), 32'd4);
        chk("t2_x", x_o, 32'hFFEB0000);
        wait_tick(10, n);
        chk("t3_period", 32'(n), 32'd4);
        chk("t3_x", x_o, 32'h7FFF0000);
        chk("t3_uf", 32'(underflow_o), 32'd0);
        wait_tick(10, n);
        chk("t4_period", 32'(n), 32'd4);
        chk("t4_x", x_o, 32'd0);
        chk("t4_uf", 32'(underflow_o), 32'd1);
        en_i = 1'b0;
        step();
        chk("hold_tick", 32'(tick_o), 32'd0);
        chk("hold_x", x_o, 32'd0);

        // Clear with FIFO non-empty, then clear vs. empty tick.
        s_if.s_valid_i = 1'b1;
        s_if.s_data_i = 16'h0005;
        step();
        s_if.s_valid_i = 1'b0;
        chk("lvl1", 32'(level_o), 32'd1);
        chk("uf_sticky", 32'(underflow_o), 32'd1);
        clr_uf_i = 1'b1;
        step();
        clr_uf_i = 1'b0;
        chk("uf_cleared", 32'(underflow_o), 32'd0);
        div_i = 16'd0;
        en_i = 1'b1;
        step();
        chk("d0_x", x_o, 32'h00050000);
        chk("d0_tick", 32'(tick_o), 32'd1);
        chk("d0_uf", 32'(underflow_o), 32'd0);
        clr_uf_i = 1'b1;
        step();
        clr_uf_i = 1'b0;
        en_i = 1'b0;
        chk("clr_vs_uf", 32'(underflow_o), 32'd1);
        chk("clr_vs_uf_x", x_o, 32'd0);
        clr_uf_i = 1'b1;
        step();
        clr_uf_i = 1'b0;
        chk("uf_clr2", 32'(underflow_o), 32'd0);

        // Fill with valid held for 20 cycles.
        acc = 0;
        s_if.s_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_if.s_data_i = 16'(16'h0100 + acc);
            w = s_if.s_ready_o;
            step();
            if (w) acc++;
        end
        chk("fill_acc", 32'(acc), 32'd16);
        chk("fill_lvl", 32'(level_o), 32'd16);
        chk("fill_ready", 32'(s_if.s_ready_o), 32'd0);

        // Full FIFO streaming at one push and one pop per cycle.
        en_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_if.s_data_i = 16'(16'h0100 + acc);
            w = s_if.s_ready_o;
            step();
            if (w) acc++;
            chk("strm_x", x_o, {16'(16'h0100 + i), 16'h0000});
            chk("strm_lvl", 32'(level_o), 32'd15);
            chk("strm_tick", 32'(tick_o), 32'd1);
        end
        chk("strm_uf", 32'(underflow_o), 32'd0);
        s_if.s_valid_i = 1'b0;

        // Drain to level 5, then reset mid-count.
        for (int i = 0; i < 10; i++) step();
        chk("drain_lvl", 32'(level_o), 32'd5);
        chk("drain_x", x_o, 32'h010F0000);
        div_i = 16'd7;
        step();
        step();
        chk("mid_tick", 32'(tick_o), 32'd0);
        rst = 1'b1;
        step();
        chk("mrst_lvl", 32'(level_o), 32'd0);
        chk("mrst_x", x_o, 32'd0);
        chk("mrst_tick", 32'(tick_o), 32'd0);
        chk("mrst_ready", 32'(s_if.s_ready_o), 32'd0);
        rst = 1'b0;
        en_i = 1'b0;
        #1;
        chk("mrst_ready1", 32'(s_if.s_ready_o), 32'd1);
        s_if.s_valid_i = 1'b1;
        s_if.s_data_i = 16'h1234;
        step();
        s_if.s_valid_i = 1'b0;
        div_i = 16'd1;
        en_i = 1'b1;
        wait_tick(10, n);
        chk("post_period", 32'(n), 32'd2);
        chk("post_x", x_o, 32'h12340000);
        chk("post_uf", 32'(underflow_o), 32'd0);

        // Push coinciding with a tick on an empty FIFO.
        en_i = 1'b0;
        step();
        div_i = 16'd0;
        en_i = 1'b1;
        s_if.s_valid_i = 1'b1;
        s_if.s_data_i = 16'h4321;
        step();
        s_if.s_valid_i = 1'b0;
        chk("same_x", x_o, 32'd0);
        chk("same_uf", 32'(underflow_o), 32'd1);
        chk("same_lvl", 32'(level_o), 32'd1);
        step();
        chk("same_next_x", x_o, 32'h43210000);
        chk("same_next_lvl", 32'(level_o), 32'd0);
        en_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
